// File: rtl/ls_rs_pkg.sv
// ls_rs_pkg: shared types and defaults for the ordered LS station.
// Entry layout, load/store type codes and default widths.
package ls_rs_pkg;

  localparam int LS_DEPTH  = 16;
  localparam int LS_ROB_W  = 5;
  localparam int LS_XLEN   = 32;
  localparam int LS_TYPE_W = 7;
  localparam int LS_WAKE   = 5;

  localparam logic [LS_TYPE_W-1:0] LS_LB  = 7'h00;
  localparam logic [LS_TYPE_W-1:0] LS_LH  = 7'h01;
  localparam logic [LS_TYPE_W-1:0] LS_LW  = 7'h02;
  localparam logic [LS_TYPE_W-1:0] LS_LBU = 7'h04;
  localparam logic [LS_TYPE_W-1:0] LS_LHU = 7'h05;
  localparam logic [LS_TYPE_W-1:0] LS_SB  = 7'h08;
  localparam logic [LS_TYPE_W-1:0] LS_SH  = 7'h09;
  localparam logic [LS_TYPE_W-1:0] LS_SW  = 7'h0a;

  typedef struct packed {
    logic [LS_TYPE_W-1:0] typ;
    logic [LS_ROB_W-1:0]  rob_id;
    logic [LS_XLEN-1:0]   v1;
    logic [LS_XLEN-1:0]   sv;
    logic [LS_XLEN-1:0]   imm;
    logic                 d1v;
    logic [LS_ROB_W-1:0]  d1;
    logic                 d2v;
    logic [LS_ROB_W-1:0]  d2;
  } ls_entry_t;

endpackage

// File: rtl/ls_rs_age_pick.sv
// ls_rs_age_pick: age matrix and oldest-ready / oldest-valid picker.
// Ports: alloc_oh/busy/ready per entry in; one-hot grant + gnt_valid out.
module ls_rs_age_pick
  import ls_rs_pkg::*;
#(
  parameter int DEPTH    = LS_DEPTH,
  parameter int IN_ORDER = 0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] busy,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant,
  output logic             gnt_valid
);

  // older[i][j] = 1: entry i was allocated before entry j
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] blocked;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int k = 0; k < DEPTH; k++) older[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc_oh[k]) begin
          older[k] <= '0;
          for (int i = 0; i < DEPTH; i++)
            if (busy[i]) older[i][k] <= 1'b1;
        end
      end
    end
  end

  // in-order mode lets a blocked oldest entry stall everyone
  assign cand = (IN_ORDER != 0) ? busy : ready;

  always_comb begin
    blocked = '0;
    for (int j = 0; j < DEPTH; j++)
      for (int i = 0; i < DEPTH; i++)
        if (cand[i] && older[i][j]) blocked[j] = 1'b1;
  end

  assign grant     = cand & ready & ~blocked;
  assign gnt_valid = |grant;

endmodule

// File: rtl/ls_rs_ordered.sv
// ls_rs_ordered: age-ordered load/store reservation station.
// Dispatch in, N-port wakeup in, registered valid/ready issue out.
module ls_rs_ordered
  import ls_rs_pkg::*;
#(
  parameter int DEPTH      = LS_DEPTH,
  parameter int ROB_W      = LS_ROB_W,
  parameter int XLEN       = LS_XLEN,
  parameter int TYPE_W     = LS_TYPE_W,
  parameter int WAKE_PORTS = LS_WAKE,
  parameter int IN_ORDER   = 0
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clear_in,
  input  logic                        disp_valid,
  input  logic [TYPE_W-1:0]           disp_type,
  input  logic [ROB_W-1:0]            disp_rob_id,
  input  logic [XLEN-1:0]             disp_v1,
  input  logic [XLEN-1:0]             disp_sv,
  input  logic [XLEN-1:0]             disp_imm,
  input  logic                        disp_dep1_valid,
  input  logic                        disp_dep2_valid,
  input  logic [ROB_W-1:0]            disp_dep1,
  input  logic [ROB_W-1:0]            disp_dep2,
  output logic                        full_out,
  output logic [$clog2(DEPTH):0]      count_out,
  input  logic [WAKE_PORTS-1:0]       wake_valid,
  input  logic [WAKE_PORTS*ROB_W-1:0] wake_rob_id,
  input  logic [WAKE_PORTS*XLEN-1:0]  wake_value,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [TYPE_W-1:0]           iss_type,
  output logic [ROB_W-1:0]            iss_rob_id,
  output logic [XLEN-1:0]             iss_addr,
  output logic [XLEN-1:0]             iss_st_value
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [ROB_W-1:0]  rob_id;
    logic [XLEN-1:0]   v1;
    logic [XLEN-1:0]   sv;
    logic [XLEN-1:0]   imm;
    logic              d1v;
    logic [ROB_W-1:0]  d1;
    logic              d2v;
    logic [ROB_W-1:0]  d2;
  } ent_t;

  ent_t             ent   [DEPTH];
  ent_t             ent_n [DEPTH];
  ent_t             new_e;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_n;
  logic [DEPTH-1:0] rdy_vec;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] grant;
  logic             gnt_valid;
  logic             alloc;
  logic             move;
  logic [ROB_W-1:0] w_tag [WAKE_PORTS];
  logic [XLEN-1:0]  w_val [WAKE_PORTS];

  always_comb begin
    for (int p = 0; p < WAKE_PORTS; p++) begin
      w_tag[p] = wake_rob_id[p*ROB_W +: ROB_W];
      w_val[p] = wake_value[p*XLEN +: XLEN];
    end
  end

  assign full_out = (count_out == CW'(DEPTH));
  assign alloc    = rdy_in && !clear_in && disp_valid && !full_out;
  assign move     = rdy_in && !clear_in && gnt_valid &&
                    (!iss_valid || iss_ready);

  // descending scan so the lowest free index wins
  always_comb begin
    free_oh = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

  assign alloc_oh = alloc ? free_oh : '0;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      rdy_vec[i] = busy[i] && !ent[i].d1v && !ent[i].d2v;
  end

  // ports scanned high to low so port 0 has the final say
  always_comb begin
    new_e.typ    = disp_type;
    new_e.rob_id = disp_rob_id;
    new_e.v1     = disp_v1;
    new_e.sv     = disp_sv;
    new_e.imm    = disp_imm;
    new_e.d1v    = disp_dep1_valid;
    new_e.d1     = disp_dep1;
    new_e.d2v    = disp_dep2_valid;
    new_e.d2     = disp_dep2;
    for (int p = WAKE_PORTS-1; p >= 0; p--) begin
      if (wake_valid[p] && disp_dep1_valid &&
          disp_dep1 == w_tag[p]) begin
        new_e.d1v = 1'b0;
        new_e.v1  = w_val[p];
      end
      if (wake_valid[p] && disp_dep2_valid &&
          disp_dep2 == w_tag[p]) begin
        new_e.d2v = 1'b0;
        new_e.sv  = w_val[p];
      end
    end
  end

  always_comb begin
    ent_n = ent;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy[i]) begin
        for (int p = WAKE_PORTS-1; p >= 0; p--) begin
          if (wake_valid[p] && ent[i].d1v &&
              ent[i].d1 == w_tag[p]) begin
            ent_n[i].d1v = 1'b0;
            ent_n[i].v1  = w_val[p];
          end
          if (wake_valid[p] && ent[i].d2v &&
              ent[i].d2 == w_tag[p]) begin
            ent_n[i].d2v = 1'b0;
            ent_n[i].sv  = w_val[p];
          end
        end
      end
      if (alloc_oh[i]) ent_n[i] = new_e;
    end
  end

  assign busy_n = (busy | alloc_oh) & ~(move ? grant : '0);

  ls_rs_age_pick #(
    .DEPTH    (DEPTH),
    .IN_ORDER (IN_ORDER)
  ) u_pick (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .alloc_oh  (alloc_oh),
    .busy      (busy),
    .ready     (rdy_vec),
    .grant     (grant),
    .gnt_valid (gnt_valid)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy         <= '0;
      count_out    <= '0;
      iss_valid    <= 1'b0;
      iss_type     <= '0;
      iss_rob_id   <= '0;
      iss_addr     <= '0;
      iss_st_value <= '0;
    end else if (clear_in) begin
      busy      <= '0;
      count_out <= '0;
      iss_valid <= 1'b0;
    end else if (rdy_in) begin
      busy      <= busy_n;
      count_out <= count_out + CW'(alloc) - CW'(move);
      if (move) begin
        iss_valid <= 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (grant[i]) begin
            iss_type     <= ent[i].typ;
            iss_rob_id   <= ent[i].rob_id;
            iss_addr     <= ent[i].v1 + ent[i].imm;
            iss_st_value <= ent[i].sv;
          end
        end
      end else if (iss_ready) begin
        iss_valid <= 1'b0;
      end
    end
  end

  // payload needs no reset; busy gates every use
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear_in) ent <= ent_n;
  end

endmodule
